reg_share_arbiter: RTL and testbench

REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

---
 rtl/reg_share_arbiter.sv | 140 ++++++++++++++
 tb/tb_reg_share_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/reg_share_arbiter.sv
// Four-requester arbiter guarding one shared WIDTH-bit register (IDLE -> GRANT -> DONE).
// Define RR_ARB_EN for round-robin selection; otherwise the lowest requesting index wins.
module reg_share_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] din,
    output logic [3:0]         gnt,
    output logic [WIDTH-1:0]   q,
    output logic               ack,
    output logic               busy,
    output logic [7:0]         wr_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       win_q, win_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ack_q, ack_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [1:0]       pick;
    logic [WIDTH-1:0] lane [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = din[gi*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef RR_ARB_EN
    logic [1:0] ptr_q, ptr_d;

    // Search starts at the pointer and walks upward modulo 4.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        pick  = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end
`else
    // Descending scan so the lowest set index is the last assignment.
    always_comb begin
        pick = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                pick = 2'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        gnt_d   = 4'b0000;
        data_d  = data_q;
        ack_d   = 1'b0;
        cnt_d   = cnt_q;
`ifdef RR_ARB_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    win_d   = pick;
                    gnt_d   = 4'b0001 << pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // The winner must still be requesting, otherwise the grant is dropped.
                if (req[win_q]) begin
                    data_d  = lane[win_q];
                    cnt_d   = cnt_q + 8'd1;
                    ack_d   = 1'b1;
                    state_d = DONE;
`ifdef RR_ARB_EN
                    ptr_d   = win_q + 2'd1;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            data_q  <= '0;
            ack_q   <= 1'b0;
            cnt_q   <= 8'd0;
`ifdef RR_ARB_EN
            ptr_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
`ifdef RR_ARB_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign gnt    = gnt_q;
    assign q      = data_q;
    assign ack    = ack_q;
    assign busy   = (state_q != IDLE);
    assign wr_cnt = cnt_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Randomized and directed bench for reg_share_arbiter against a transaction-phase reference model.
// Build with RR_ARB_EN defined for both files to exercise round-robin selection.
module tb_reg_share_arbiter;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [3:0]     req;
    logic [4*W-1:0] din;
    logic [3:0]     gnt;
    logic [W-1:0]   q;
    logic           ack;
    logic           busy;
    logic [7:0]     wr_cnt;

    int errors;
    int checks;

    // Reference state: phase 0 = idle, 1 = holding a grant, 2 = write just committed.
    int         m_phase;
    int         m_win;
    int         m_ptr;
    logic [3:0] m_gnt;
    logic [7:0] m_q;
    logic       m_ack;
    int         m_cnt;

    reg_share_arbiter #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .din    (din),
        .gnt    (gnt),
        .q      (q),
        .ack    (ack),
        .busy   (busy),
        .wr_cnt (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int choose(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_win   = 0;
        m_ptr   = 0;
        m_gnt   = 4'b0000;
        m_q     = 8'h00;
        m_ack   = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic [4*W-1:0] d);
        if (rst) begin
            model_reset();
        end else if (m_phase == 0) begin
            m_ack = 1'b0;
            if (r != 4'b0000) begin
                m_win   = choose(r, m_ptr);
                m_gnt   = 4'b0001 << m_win;
                m_phase = 1;
            end else begin
                m_gnt = 4'b0000;
            end
        end else if (m_phase == 1) begin
            m_gnt = 4'b0000;
            if (r[m_win]) begin
                m_q     = d[m_win*W +: W];
                m_cnt   = (m_cnt + 1) % 256;
                m_ack   = 1'b1;
                m_phase = 2;
`ifdef RR_ARB_EN
                m_ptr   = (m_win + 1) % 4;
`endif
            end else begin
                m_phase = 0;
            end
        end else begin
            m_ack   = 1'b0;
            m_phase = 0;
        end
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, ".gnt"}, 32'(gnt), 32'(m_gnt));
        check({ctx, ".q"}, 32'(q), 32'(m_q));
        check({ctx, ".ack"}, 32'(ack), 32'(m_ack));
        check({ctx, ".busy"}, 32'(busy), 32'(m_phase != 0));
        check({ctx, ".wr_cnt"}, 32'(wr_cnt), 32'(m_cnt));
        check({ctx, ".onehot0"}, 32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic step(input string ctx, input logic [3:0] r, input logic [4*W-1:0] d);
        @(negedge clk);
        req = r;
        din = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
        compare_all(ctx);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        #1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare_all("reset");
    endtask

    initial begin
        logic [7:0] last_b;
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        req    = 4'b0000;
        din    = '0;
        model_reset();

        do_reset();

        // Single request on lane 2
        step("single", 4'b0100, 32'h00A50000);
        step("single", 4'b0100, 32'h00A50000);
        step("single", 4'b0000, 32'h00A50000);
        step("single", 4'b0000, 32'h00000000);
        check("single.q_final", 32'(q), 32'h000000A5);
        check("single.cnt_final", 32'(wr_cnt), 32'd1);

        // Abort: requester 0 drops during its grant
        step("abort", 4'b0001, 32'h000000EE);
        step("abort", 4'b0000, 32'h000000EE);
        step("abort", 4'b0000, 32'h00000000);

        // Full contention, then requesters 1 and 3 only
        do_reset();
        for (int i = 0; i < 15; i++) step("rr4", 4'b1111, 32'h13121110);
        for (int i = 0; i < 9; i++) step("pair", 4'b1010, 32'h13121110);

        // Asynchronous reset in the middle of a grant
        step("mid", 4'b0010, 32'h00003C00);
        check("mid.in_grant", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid.async_gnt", 32'(gnt), 32'd0);
        check("mid.async_q", 32'(q), 32'd0);
        check("mid.async_cnt", 32'(wr_cnt), 32'd0);
        check("mid.async_ack", 32'(ack), 32'd0);
        check("mid.async_busy", 32'(busy), 32'd0);
        model_reset();
        step("mid_hold", 4'b0000, 32'h00003C00);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step("mid_after", 4'b0000, 32'h00003C00);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            step("rand", r, 32'($urandom));
        end

        // 256 committed writes from reset wrap the counter back to zero
        do_reset();
        last_b = 8'h00;
        for (int t = 0; t < 256; t++) begin
            logic [3:0] r;
            last_b = 8'($urandom);
            r = 4'b0001 << (t % 4);
            for (int c = 0; c < 3; c++) step("wrap", r, {4{last_b}});
        end
        check("wrap.cnt_zero", 32'(wr_cnt), 32'd0);
        check("wrap.q_last", 32'(q), 32'(last_b));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
